// File: rtl/control_status_register_file.sv
// Machine-mode CSR storage for the phoeniX core: combinational read port,
// edge-committed writes, 64-bit cycle/instret counters and illegal-access flag.
module control_status_register_file #(
  parameter logic [31:0] MISA_VALUE    = 32'h40001104,
  parameter logic [31:0] MHARTID_VALUE = 32'h00000000,
  parameter logic [31:0] MTVEC_RESET   = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_read_enable,
  input  logic [11:0] csr_address,
  output logic [31:0] csr_read_data,
  input  logic        csr_write_enable,
  input  logic [31:0] csr_write_data,
  input  logic        instret_increment,
  output logic        illegal_access
);

  localparam logic [11:0] addr_mstatus   = 12'h300;
  localparam logic [11:0] addr_misa      = 12'h301;
  localparam logic [11:0] addr_mie       = 12'h304;
  localparam logic [11:0] addr_mtvec     = 12'h305;
  localparam logic [11:0] addr_mscratch  = 12'h340;
  localparam logic [11:0] addr_mepc      = 12'h341;
  localparam logic [11:0] addr_mcause    = 12'h342;
  localparam logic [11:0] addr_mtval     = 12'h343;
  localparam logic [11:0] addr_mip       = 12'h344;
  localparam logic [11:0] addr_mcycle    = 12'hB00;
  localparam logic [11:0] addr_minstret  = 12'hB02;
  localparam logic [11:0] addr_mcycleh   = 12'hB80;
  localparam logic [11:0] addr_minstreth = 12'hB82;
  localparam logic [11:0] addr_cycle     = 12'hC00;
  localparam logic [11:0] addr_instret   = 12'hC02;
  localparam logic [11:0] addr_cycleh    = 12'hC80;
  localparam logic [11:0] addr_instreth  = 12'hC82;
  localparam logic [11:0] addr_mhartid   = 12'hF14;

  logic        mstatus_mie, mstatus_mpie;
  logic [2:0]  mie_bits;                 // mie bits {11, 7, 3}
  logic [31:0] mtvec, mscratch, mcause, mtval;
  logic [31:2] mepc;
  logic [63:0] mcycle, minstret;

  logic implemented, read_only, write_commit;

  always_comb begin
    csr_read_data = '0;
    implemented   = 1'b1;
    read_only     = 1'b0;
    case (csr_address)
      addr_mstatus:   csr_read_data = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      addr_misa:      begin csr_read_data = MISA_VALUE; read_only = 1'b1; end
      addr_mie:       csr_read_data = {20'b0, mie_bits[2], 3'b0, mie_bits[1], 3'b0, mie_bits[0], 3'b0};
      addr_mtvec:     csr_read_data = mtvec;
      addr_mscratch:  csr_read_data = mscratch;
      addr_mepc:      csr_read_data = {mepc, 2'b00};
      addr_mcause:    csr_read_data = mcause;
      addr_mtval:     csr_read_data = mtval;
      addr_mip:       read_only = 1'b1;
      addr_mcycle:    csr_read_data = mcycle[31:0];
      addr_mcycleh:   csr_read_data = mcycle[63:32];
      addr_minstret:  csr_read_data = minstret[31:0];
      addr_minstreth: csr_read_data = minstret[63:32];
      addr_cycle:     begin csr_read_data = mcycle[31:0];    read_only = 1'b1; end
      addr_cycleh:    begin csr_read_data = mcycle[63:32];   read_only = 1'b1; end
      addr_instret:   begin csr_read_data = minstret[31:0];  read_only = 1'b1; end
      addr_instreth:  begin csr_read_data = minstret[63:32]; read_only = 1'b1; end
      addr_mhartid:   begin csr_read_data = MHARTID_VALUE;   read_only = 1'b1; end
      default:        implemented = 1'b0;
    endcase
  end

  // misa and mip sit outside the 2'b11 read-only encoding but are still read-only.
  assign illegal_access = csr_read_enable &
                          (~implemented | (csr_write_enable & ((csr_address[11:10] == 2'b11) | read_only)));
  assign write_commit   = csr_write_enable & csr_read_enable & implemented & ~read_only & ~illegal_access;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_bits     <= '0;
      mtvec        <= MTVEC_RESET & ~32'h2;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
      mcycle       <= '0;
      minstret     <= '0;
    end else begin
      if (write_commit) begin
        case (csr_address)
          addr_mstatus:  begin mstatus_mie <= csr_write_data[3]; mstatus_mpie <= csr_write_data[7]; end
          addr_mie:      mie_bits <= {csr_write_data[11], csr_write_data[7], csr_write_data[3]};
          addr_mtvec:    mtvec    <= {csr_write_data[31:2], 1'b0, csr_write_data[0]};
          addr_mscratch: mscratch <= csr_write_data;
          addr_mepc:     mepc     <= csr_write_data[31:2];
          addr_mcause:   mcause   <= csr_write_data;
          addr_mtval:    mtval    <= csr_write_data;
          default: ;
        endcase
      end

      // A write to either half of a counter suppresses that counter's increment.
      if (write_commit && csr_address == addr_mcycle)
        mcycle <= {mcycle[63:32], csr_write_data};
      else if (write_commit && csr_address == addr_mcycleh)
        mcycle <= {csr_write_data, mcycle[31:0]};
      else
        mcycle <= mcycle + 64'd1;

      if (write_commit && csr_address == addr_minstret)
        minstret <= {minstret[63:32], csr_write_data};
      else if (write_commit && csr_address == addr_minstreth)
        minstret <= {csr_write_data, minstret[31:0]};
      else if (instret_increment)
        minstret <= minstret + 64'd1;
    end
  end

endmodule
